// File: rtl/uw_frame_inserter_pkg.sv
// uw_pkg: shared constants, state encoding and QPSK rotation for the UW framer and resolver
package uw_pkg;
    localparam int UW_LEN = 16;
    localparam int SYM_W  = 2;
    localparam int IDX_W  = 14;

    typedef enum logic [1:0] {IDLE, UW, PAYLOAD} state_t;

    // One +90 degree step on a {q,i} symbol: new_i = ~q, new_q = i
    function automatic logic [SYM_W-1:0] rot90(input logic [SYM_W-1:0] sym);
        return {sym[0], ~sym[1]};
    endfunction
endpackage

// File: rtl/uw_frame_inserter_if.sv
// uw_frame_inserter_if: payload-in and framed-out valid/ready symbol streams
interface uw_frame_inserter_if;
    logic [uw_pkg::SYM_W-1:0] in_sym;
    logic                     in_valid;
    logic                     in_ready;
    logic [uw_pkg::SYM_W-1:0] out_sym;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sof;
    logic                     out_eof;

    modport master (
        output in_sym, in_valid, out_ready,
        input  in_ready, out_sym, out_valid, out_sof, out_eof
    );

    modport slave (
        input  in_sym, in_valid, out_ready,
        output in_ready, out_sym, out_valid, out_sof, out_eof
    );
endinterface

// File: rtl/uw_frame_inserter_qpsk_rotator.sv
// qpsk_rotator: rotates a {q,i} symbol by rot steps of +90 degrees
module qpsk_rotator
    import uw_pkg::*;
(
    input  logic [SYM_W-1:0] sym_in,
    input  logic [1:0]       rot,
    output logic [SYM_W-1:0] sym_out
);
    logic [SYM_W-1:0] r1, r2, r3;

    // Chain of single steps, then pick the requested amount
    always_comb begin
        r1      = rot90(sym_in);
        r2      = rot90(r1);
        r3      = rot90(r2);
        sym_out = rot == 2'd0 ? sym_in : rot == 2'd1 ? r1 : rot == 2'd2 ? r2 : r3;
    end
endmodule

// File: rtl/uw_frame_inserter.sv
// uw_frame_inserter: prepends the 16-symbol unique word to each payload; UW_ROT_EN adds per-frame rotation
module uw_frame_inserter
    import uw_pkg::*;
#(
    parameter int PAYLOAD_LEN = 1008,
    parameter int FCNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [31:0]       uw_pattern,
`ifdef UW_ROT_EN
    input  logic [1:0]        rot,
`endif
    uw_frame_inserter_if.slave io,
    output logic [IDX_W-1:0]  sym_index,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam logic [IDX_W-1:0] UW_LAST  = IDX_W'(UW_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UW_LEN + PAYLOAD_LEN - 1);

    state_t             state_q, state_d;
    logic [31:0]        uw_q, uw_d;
    logic [IDX_W-1:0]   pos_q, pos_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic               valid_q, valid_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

    logic               load, take, from_uw, last;
    logic [31:0]        uw_src;
    logic [SYM_W-1:0]   raw_sym, rot_sym;

    // pos_q is the frame position of the next symbol to load; in IDLE a starting
    // frame reads uw_pattern directly so its first symbol is valid one cycle after en
    assign load        = !valid_q || io.out_ready;
    assign from_uw     = state_q == UW || (state_q == IDLE && en);
    assign take        = load && (from_uw || (state_q == PAYLOAD && io.in_valid));
    assign last        = pos_q == LAST_IDX;
    assign uw_src      = state_q == IDLE ? uw_pattern : uw_q;
    assign raw_sym     = from_uw ? uw_src[{4'd15 - pos_q[3:0], 1'b0} +: SYM_W] : io.in_sym;
    assign io.in_ready = state_q == PAYLOAD && load;

`ifdef UW_ROT_EN
    logic [1:0] rot_q, rot_d, rot_src;

    assign rot_src = state_q == IDLE ? rot : rot_q;

    qpsk_rotator u_rot (
        .sym_in (raw_sym),
        .rot    (rot_src),
        .sym_out(rot_sym)
    );

    // Rotation amount register, captured with the UW at each frame start
    always_ff @(posedge clk) begin
        if (rst) rot_q <= '0;
        else     rot_q <= rot_d;
    end
`else
    assign rot_sym = raw_sym;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            uw_q    <= '0;
            pos_q   <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            idx_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            uw_q    <= uw_d;
            pos_q   <= pos_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Frame sequencing: IDLE -> UW -> PAYLOAD -> UW/IDLE, advancing only on loads
    always_comb begin
        state_d = state_q;
        uw_d    = uw_q;
        pos_d   = pos_q;
`ifdef UW_ROT_EN
        rot_d   = rot_q;
`endif
        if (state_q == IDLE) begin
            if (en) begin
                state_d = UW;
                uw_d    = uw_pattern;
                pos_d   = IDX_W'(take);
`ifdef UW_ROT_EN
                rot_d   = rot;
`endif
            end
        end else if (take) begin
            pos_d = pos_q + 1'b1;
            if (state_q == UW && pos_q == UW_LAST)
                state_d = PAYLOAD;
            if (state_q == PAYLOAD && last) begin
                state_d = en ? UW : IDLE;
                pos_d   = '0;
                if (en) begin
                    uw_d  = uw_pattern;
`ifdef UW_ROT_EN
                    rot_d = rot;
`endif
                end
            end
        end
    end

    // Output register: load when empty or accepted, bubble when nothing is available
    always_comb begin
        sym_d   = take ? rot_sym : sym_q;
        valid_d = take || (valid_q && !load);
        sof_d   = take ? (from_uw && pos_q == '0) : (load ? 1'b0 : sof_q);
        eof_d   = take ? (state_q == PAYLOAD && last) : (load ? 1'b0 : eof_q);
        idx_d   = take ? pos_q : idx_q;
        fcnt_d  = fcnt_q + FCNT_W'(valid_q && io.out_ready && eof_q);
    end

    assign io.out_sym   = sym_q;
    assign io.out_valid = valid_q;
    assign io.out_sof   = sof_q;
    assign io.out_eof   = eof_q;
    assign sym_index    = idx_q;
    assign frame_cnt    = fcnt_q;
endmodule

// File: tb/tb_uw_frame_inserter.sv
// tb_uw_frame_inserter: scoreboard bench for uw_frame_inserter with PAYLOAD_LEN=4
module tb_uw_frame_inserter;
    import uw_pkg::*;

    localparam int PL = 4;

    typedef struct packed {
        logic [1:0]  sym;
        logic        sof;
        logic        eof;
        logic [13:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] uw_pattern = '0;
`ifdef UW_ROT_EN
    logic [1:0]  rot = 2'd0;
`endif
    logic [13:0] sym_index;
    logic [15:0] frame_cnt;

    uw_frame_inserter_if bus ();

    uw_frame_inserter #(.PAYLOAD_LEN(PL), .FCNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .uw_pattern(uw_pattern),
`ifdef UW_ROT_EN
        .rot       (rot),
`endif
        .io        (bus),
        .sym_index (sym_index),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    logic [1:0] src_q[$];
    int n_chk = 0, n_fail = 0, cyc_n = 0, t_sof1 = -1, bubbles = 0, r5 = 0;
    logic tog = 1'b0, phase = 1'b0, feed = 1'b0;

    localparam logic [31:0] UW1 = 32'b10011100011000110110010101101111;
    localparam logic [31:0] UW2 = 32'hA5C3_0F96;
    localparam logic [31:0] UW3 = 32'h3C5A_E1B7;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // +90 degree steps walk the constellation ring 00 -> 01 -> 11 -> 10
    function automatic logic [1:0] rot_m(input logic [1:0] s, input int r);
        logic [1:0] ring [4];
        int p = 0;
        ring = '{2'b00, 2'b01, 2'b11, 2'b10};
        for (int k = 0; k < 4; k++) if (ring[k] == s) p = k;
        return ring[(p + r) % 4];
    endfunction

    task automatic push_frame(input logic [31:0] uw, input logic [7:0] pl, input int r);
        exp_t e;
        logic [1:0] s;
        for (int k = 0; k < 16; k++) begin
            e.sym = rot_m(uw[2*(15-k) +: 2], r);
            e.sof = (k == 0);
            e.eof = 1'b0;
            e.idx = 14'(k);
            exp_q.push_back(e);
        end
        for (int j = 0; j < PL; j++) begin
            s = pl[2*(3-j) +: 2];
            src_q.push_back(s);
            e.sym = rot_m(s, r);
            e.sof = 1'b0;
            e.eof = (j == PL - 1);
            e.idx = 14'(16 + j);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_sym", 32'(bus.out_sym), 32'(e.sym));
                chk("out_sof", 32'(bus.out_sof), 32'(e.sof));
                chk("out_eof", 32'(bus.out_eof), 32'(e.eof));
                chk("sym_index", 32'(sym_index), 32'(e.idx));
                chk("in_ready", 32'(bus.in_ready), 32'(e.idx >= 15 && e.idx < 15 + PL));
                if (e.sof && t_sof1 < 0) t_sof1 = cyc_n;
            end
        end else if (!bus.out_valid && exp_q.size() > 0 && exp_q[0].idx != 0) begin
            bubbles++;
        end
        if (bus.in_valid && bus.in_ready) void'(src_q.pop_front());
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        phase = ~phase;
        bus.in_valid = feed && src_q.size() > 0 && (!tog || phase);
        bus.in_sym   = src_q.size() > 0 ? src_q[0] : 2'b00;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int n;
        bus.in_sym    = 2'b00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_sym", 32'(bus.out_sym), 0);
        chk("rst_sof", 32'(bus.out_sof), 0);
        chk("rst_eof", 32'(bus.out_eof), 0);
        chk("rst_sym_index", 32'(sym_index), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_out_valid", 32'(bus.out_valid), 0);
            chk("idle_in_ready", 32'(bus.in_ready), 0);
            chk("idle_frame_cnt", 32'(frame_cnt), 0);
        end

        // Frames 1 and 2 back to back
        push_frame(UW1, 8'b00_01_10_11, 0);
        push_frame(UW2, 8'b11_01_10_00, 0);
        feed = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sym   = src_q[0];
        uw_pattern = UW1;
        en = 1'b1;
        tick();
        chk("first_sof_latency", 32'(bus.out_valid && bus.out_sof), 1);
        uw_pattern = UW2;
        n = 0;
        while (!(bus.out_valid && sym_index == 14'd5 && frame_cnt == 16'd1) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_f2_idx5", 32'(n < 100), 1);
        chk("no_gap", 32'(cyc_n - t_sof1), 25);
        chk("frame_cnt_1", 32'(frame_cnt), 1);
        en = 1'b0;

        // Backpressure at sym_index 5
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_sym", 32'(bus.out_sym), 32'(exp_q[0].sym));
            chk("bp_index", 32'(sym_index), 32'(exp_q[0].idx));
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        drain("drain_f2");
        tick();
        chk("frame_cnt_2", 32'(frame_cnt), 2);
        chk("idle_after_f2", 32'(bus.out_valid), 0);

        // Frame 3 with toggling in_valid
        bubbles = 0;
        tog = 1'b1;
        push_frame(UW3, 8'b10_00_11_01, 0);
        uw_pattern = UW3;
        en = 1'b1;
        tick();
        en = 1'b0;
        drain("drain_f3");
        tick();
        chk("frame_cnt_3", 32'(frame_cnt), 3);
        chk("bubbles_seen", 32'(bubbles > 0), 1);
        tog = 1'b0;

        // Frame 4 aborted by reset at sym_index 10
        push_frame(UW2, 8'b01_10_11_00, 0);
        uw_pattern = UW2;
        en = 1'b1;
        tick();
        en = 1'b0;
        n = 0;
        while (!(bus.out_valid && sym_index == 14'd10) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_f4_idx10", 32'(n < 100), 1);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_out_sym", 32'(bus.out_sym), 0);
        chk("abort_sof", 32'(bus.out_sof), 0);
        chk("abort_eof", 32'(bus.out_eof), 0);
        chk("abort_sym_index", 32'(sym_index), 0);
        chk("abort_frame_cnt", 32'(frame_cnt), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 0);
        exp_q.delete();
        src_q.delete();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;

        // Frame 5 restarts cleanly, rotated when the option is built
`ifdef UW_ROT_EN
        r5 = 1;
        rot = 2'd1;
`endif
        push_frame(UW1, 8'b00_01_10_11, r5);
        uw_pattern = UW1;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("f5_sof", 32'(bus.out_valid && bus.out_sof), 1);
        chk("f5_first_sym", 32'(bus.out_sym), r5 == 1 ? 32'h0 : 32'h2);
        drain("drain_f5");
        tick();
        chk("frame_cnt_after_rst", 32'(frame_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
